// File: rtl/eth_model_pkg.sv
// eth_model_pkg: shared word layout, widths and unpacker state encoding.
package eth_model_pkg;
  localparam int SYMBOLS    = 4;
  localparam int BYTE_W     = 8;
  localparam int DATA_WIDTH = 37;
  localparam int EMPTY_LSB  = 32;
  localparam int EOP_BIT    = 34;
  localparam int SOP_BIT    = 35;
  localparam int ERR_BIT    = 36;
  typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/eth_model_st_checker.sv
// eth_model_st_checker: sticky Avalon-ST framing checker snooping accepted input words.
module eth_model_st_checker
  import eth_model_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  protocol_error
);
  logic in_pkt_q, err_q, accept, sop, eop, bad;
  assign accept = in_valid && in_ready;
  assign sop    = in_data[SOP_BIT];
  assign eop    = in_data[EOP_BIT];
  assign bad    = accept && ((sop && in_pkt_q) || (!sop && !in_pkt_q) ||
                             (!eop && in_data[EMPTY_LSB +: 2] != 2'd0));
  assign protocol_error = err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) in_pkt_q <= !eop;
      if (bad) err_q <= 1'b1;
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk)
    if (reset_n && bad) $display("[%0t] eth_model_st_checker: protocol violation, word %h", $time, in_data);
`endif
endmodule

// File: rtl/eth_model_unpack_32to8.sv
// eth_model_unpack_32to8: 32-bit Avalon-ST word to big-endian byte stream serialiser.
// Define UNPACK_PROTO_CHECK_EN to enable the sticky framing checker on protocol_error.
module eth_model_unpack_32to8
  import eth_model_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [BYTE_W-1:0]     out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  out_error,
  input  logic                  out_ready,
  output logic [15:0]           pkt_count,
  output logic                  protocol_error
);
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [1:0]            idx_q, idx_d, last_idx;
  logic [15:0]           pkt_q, pkt_d;
  logic                  hold, at_last, xfer, accept;
  assign hold      = state_q == SHIFT;
  assign last_idx  = word_q[EOP_BIT] ? 2'd3 - word_q[EMPTY_LSB +: 2] : 2'd3;
  assign at_last   = idx_q == last_idx;
  assign xfer      = hold && out_ready;
  assign in_ready  = !hold || (out_ready && at_last);
  assign accept    = in_valid && in_ready;
  assign out_valid = hold;
  // ~idx selects data[31:24] for idx 0 down to data[7:0] for idx 3
  assign out_data  = word_q[{~idx_q, 3'b000} +: BYTE_W];
  assign out_sop   = hold && word_q[SOP_BIT] && idx_q == 2'd0;
  assign out_eop   = hold && word_q[EOP_BIT] && at_last;
  assign out_error = word_q[ERR_BIT] && out_eop;
  assign pkt_count = pkt_q;
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    pkt_d   = pkt_q + {15'd0, xfer && out_eop};
    if (accept) begin
      state_d = SHIFT;
      word_d  = in_data;
      idx_d   = 2'd0;
    end else if (xfer) begin
      state_d = at_last ? IDLE : SHIFT;
      idx_d   = at_last ? idx_q : idx_q + 2'd1;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= 2'd0;
      pkt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      pkt_q   <= pkt_d;
    end
  end
`ifdef UNPACK_PROTO_CHECK_EN
  eth_model_st_checker u_checker (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .protocol_error (protocol_error)
  );
`else
  assign protocol_error = 1'b0;
`endif
endmodule

// File: tb/tb_eth_model_unpack_32to8.sv
// tb_eth_model_unpack_32to8: directed self-checking bench for the 32-to-8 unpacker.
module tb_eth_model_unpack_32to8;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [36:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sop, out_eop, out_error;
  logic        out_ready;
  logic [15:0] pkt_count;
  logic        protocol_error;
  int checks = 0;
  int errors = 0;
  int nbytes;
  logic exp_perr;

  eth_model_unpack_32to8 dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_error      (out_error),
    .out_ready      (out_ready),
    .pkt_count      (pkt_count),
    .protocol_error (protocol_error)
  );

  always #5 clk = ~clk;

  function automatic logic [36:0] mk(input logic err, input logic sop, input logic eop,
                                     input logic [1:0] empty, input logic [31:0] data);
    return {err, sop, eop, empty, data};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the byte presented this cycle, then advance one clock.
  task automatic byte_step(input string tag, input logic [7:0] d, input logic sop,
                           input logic eop, input logic err, input logic rdy);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".sop"}, 32'(out_sop), 32'(sop));
    chk({tag, ".eop"}, 32'(out_eop), 32'(eop));
    chk({tag, ".err"}, 32'(out_error), 32'(err));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    if (out_valid && out_ready) nbytes++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic accept_step(input string tag, input logic [36:0] w);
    in_valid = 1'b1;
    in_data  = w;
    #1;
    chk({tag, ".accept_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
`ifdef UNPACK_PROTO_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.sop_eop_err", {29'd0, out_sop, out_eop, out_error}, 32'd0);
    chk("rst.pkt_count", 32'(pkt_count), 32'd0);
    chk("rst.protocol_error", 32'(protocol_error), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // single full word
    accept_step("t1", mk(1'b0, 1'b1, 1'b1, 2'd0, 32'hA1B2C3D4));
    in_valid = 1'b0;
    byte_step("t1.b0", 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
    byte_step("t1.b1", 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t1.b2", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t1.b3", 8'hD4, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t1.idle", 32'(out_valid), 32'd0);
    chk("t1.pkt_count", 32'(pkt_count), 32'd1);

    // 3-word packet, zero-bubble word loads, last word empty=2
    nbytes = 0;
    accept_step("t2", mk(1'b0, 1'b1, 1'b0, 2'd0, 32'h01020304));
    in_data = mk(1'b0, 1'b0, 1'b0, 2'd0, 32'h05060708);
    byte_step("t2.b0", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    byte_step("t2.b1", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t2.b2", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t2.b3", 8'h04, 1'b0, 1'b0, 1'b0, 1'b1);
    in_data = mk(1'b0, 1'b0, 1'b1, 2'd2, 32'h11223344);
    byte_step("t2.b4", 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t2.b5", 8'h06, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t2.b6", 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t2.b7", 8'h08, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    byte_step("t2.b8", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t2.b9", 8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t2.nbytes", 32'(nbytes), 32'd10);
    chk("t2.idle", 32'(out_valid), 32'd0);
    chk("t2.pkt_count", 32'(pkt_count), 32'd2);

    // back-to-back packets: one-byte (empty=3) then full word
    accept_step("t3", mk(1'b0, 1'b1, 1'b1, 2'd3, 32'hEE000000));
    in_data = mk(1'b0, 1'b1, 1'b1, 2'd0, 32'h55667788);
    byte_step("t3.a0", 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b0;
    byte_step("t3.b0", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    byte_step("t3.b1", 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t3.b2", 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t3.b3", 8'h88, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t3.pkt_count", 32'(pkt_count), 32'd4);

    // mid-word stall with out_ready 1,0,0,1
    accept_step("t4", mk(1'b0, 1'b1, 1'b1, 2'd0, 32'hCAFEBABE));
    in_valid = 1'b0;
    byte_step("t4.b0", 8'hCA, 1'b1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    byte_step("t4.s0", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t4.s1", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    byte_step("t4.b1", 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t4.b2", 8'hBA, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t4.b3", 8'hBE, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t4.pkt_count", 32'(pkt_count), 32'd5);

    // error on eop word with empty=1
    accept_step("t5", mk(1'b1, 1'b1, 1'b1, 2'd1, 32'h0A0B0C0D));
    in_valid = 1'b0;
    byte_step("t5.b0", 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0);
    byte_step("t5.b1", 8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t5.b2", 8'h0C, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5.pkt_count", 32'(pkt_count), 32'd6);
    chk("t5.protocol_error", 32'(protocol_error), 32'd0);

    // async reset mid-packet, then a word without sop
    accept_step("t6", mk(1'b0, 1'b1, 1'b0, 2'd0, 32'hDEADBEEF));
    in_valid = 1'b0;
    byte_step("t6.b0", 8'hDE, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t6.rst.out_valid", 32'(out_valid), 32'd0);
    chk("t6.rst.in_ready", 32'(in_ready), 32'd1);
    chk("t6.rst.pkt_count", 32'(pkt_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    accept_step("t6n", mk(1'b0, 1'b0, 1'b1, 2'd0, 32'h12345678));
    in_valid = 1'b0;
    chk("t6.protocol_error", 32'(protocol_error), 32'(exp_perr));
    byte_step("t6.b1", 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t6.b2", 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t6.b3", 8'h56, 1'b0, 1'b0, 1'b0, 1'b0);
    byte_step("t6.b4", 8'h78, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6.sticky", 32'(protocol_error), 32'(exp_perr));
    chk("t6.pkt_count", 32'(pkt_count), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6.perr_cleared", 32'(protocol_error), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
